// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity encodings and default bit timing for the UART transmitter
package uart_pkg;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUDRATE = 115_200;
  localparam int DEFAULT_DIV = CLK_FREQ / BAUDRATE - 1;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD = 2'b10;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  function automatic logic par_en(input logic [1:0] p);
    return p == PAR_EVEN || p == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with occupancy count and fall-through read data
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop = pop && |count;
  assign rdata = mem[rptr];
  always_ff @(posedge clock)
    if (do_push) mem[wptr] <= wdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with per-frame divisor, width, parity and stop-bit config
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [1:0]                    cfg_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_e state, state_n;
  logic [DIV_WIDTH-1:0] baud, baud_n, f_div, f_div_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] sh, sh_n, head;
  logic [1:0] f_bits, f_bits_n, f_par, f_par_n;
  logic par, par_n, f_stop2, f_stop2_n, pop, tick, avail, tx_n;
  assign tick = baud == '0;
  assign avail = |fifo_count;
  assign tx_ready = fifo_count != CW'(FIFO_DEPTH);
  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(tx_valid && tx_ready),
    .pop(pop),
    .wdata(tx_data),
    .rdata(head),
    .count(fifo_count)
  );
  always_comb begin
    state_n = state;
    baud_n = tick ? f_div : baud - 1'b1;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    par_n = par;
    f_div_n = f_div;
    f_bits_n = f_bits;
    f_par_n = f_par;
    f_stop2_n = f_stop2;
    pop = 1'b0;
    case (state)
      IDLE: pop = avail;
      START: if (tick) begin
        state_n = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (tick) begin
        par_n = par ^ sh[0];
        sh_n = sh >> 1;
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == {1'b0, f_bits} + 3'd4) begin
          state_n = par_en(f_par) ? PARITY : STOP;
          bit_cnt_n = '0;
        end
      end
      PARITY: if (tick) begin
        state_n = STOP;
        bit_cnt_n = '0;
      end
      STOP: if (tick) begin
        if (f_stop2 && bit_cnt == '0) bit_cnt_n = 3'd1;
        else begin
          pop = avail;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A pop always starts a fresh frame with freshly latched configuration
    if (pop) begin
      state_n = START;
      sh_n = head;
      par_n = cfg_parity == PAR_ODD;
      f_div_n = cfg_div;
      f_bits_n = cfg_bits;
      f_par_n = cfg_parity;
      f_stop2_n = cfg_stop2;
      baud_n = cfg_div;
    end
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      f_div <= '0;
      f_bits <= '0;
      f_par <= PAR_NONE;
      f_stop2 <= 1'b0;
      uart_tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      par <= par_n;
      f_div <= f_div_n;
      f_bits <= f_bits_n;
      f_par <= f_par_n;
      f_stop2 <= f_stop2_n;
      uart_tx <= tx_n;
      busy <= state_n != IDLE;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a buffered byte FIFO and a runtime-programmable baud divisor, frame width, parity and stop-bit count. It replaces fixed, compile-time bit timing with per-frame configuration. It sits between the print/peripheral bus logic, which pushes bytes with a valid/ready handshake, and the `uart_tx` pin.

## Interface
- `FIFO_DEPTH`, 16, byte entries; must be a power of two and at least 2.
- `DIV_WIDTH`, 16, width of the baud divisor.
- `clock` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `tx_valid` in 1: a byte is offered.
- `tx_data` in 8: offered byte, LSB transmitted first.
- `tx_ready` out 1: FIFO can accept a byte.
- `cfg_div` in `DIV_WIDTH`: clocks per bit minus 1. The default tie-off is `clk_freq/baudrate-1`.
- `cfg_bits` in 2: data bits minus 5 (00 = 5 … 11 = 8).
- `cfg_parity` in 2: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2` in 1: 1 selects two stop bits.
- `uart_tx` out 1: serial line, idle high, registered.
- `busy` out 1: a frame is in progress.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: occupied FIFO entries.

## Operation
- **Push:** a byte is written on `tx_valid && tx_ready`. `tx_ready = (fifo_count != FIFO_DEPTH)`. `tx_ready` does not look ahead to a same-cycle pop.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** if the FIFO is non-empty, pop the head into the shift register, latch all `cfg_*` inputs into frame registers, and go to START. Otherwise stay in IDLE with `uart_tx=1`.
- **START:** drive 0 for one bit time, then go to DATA.
- **DATA:** shift out `cfg_bits+5` bits, LSB first, one per bit time. After the last bit, go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY:** drive the parity bit, then go to STOP.
  - Even parity: XOR of the transmitted data bits.
  - Odd parity: the inverse of that XOR.
  - Bits above `cfg_bits+5` are ignored.
- **STOP:** drive 1 for one bit time, or two if `cfg_stop2` is set.
  - At the end of the final stop bit, if the FIFO is non-empty, pop and enter START directly (no idle gap).
  - Otherwise go to IDLE.
- **Bit time:** the baud counter loads the latched divisor at each bit start and counts down; the bit ends when it reaches 0. Every bit therefore lasts exactly `div+1` cycles. `cfg_div=0` gives 1 cycle per bit.
- **Config changes:** changes to `cfg_*` mid-frame have no effect until the next frame is latched.
- **`busy`:** 1 in every state except IDLE.
- **Same-cycle push and pop:** `fifo_count` is unchanged.

## Timing
- **Reset values:** `uart_tx=1`, `busy=0`, `tx_ready=1`, `fifo_count=0`, FSM in IDLE, FIFO pointers at 0.
- **Reset mid-frame:** asynchronous return to these values; the frame in flight and all buffered bytes are discarded.
- **Latency from push to line** (push accepted at cycle N into an empty FIFO with the FSM idle):
  - `fifo_count=1` at N+1, and the FSM pops at N+1.
  - `uart_tx` goes low and `busy=1` at N+2.
- **Frame length:** (1 + bits + parity + stop) × (div+1) cycles.
- **Back-to-back frames:** the next start bit begins the cycle after the last stop-bit cycle.
- **Full FIFO:** `tx_ready=0` in the cycle after the count reaches `FIFO_DEPTH`. It returns to 1 the cycle after the FSM pops.
- **Outputs:** all outputs are registered except `tx_ready`, which is decoded from the registered count.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum.
  - Parity encoding constants.
  - Default divisor (`clk_freq/baudrate-1`, from the existing clock constants).
- **Sub-module `uart_fifo`:** synchronous FIFO parametrised by depth and width, with a count output.
- **`uart_tx_fifo`:** contains the FSM, baud counter, bit counter, shift register and parity accumulator.

## Test plan
- **8N1 basic frame:** `cfg_div=3`, 8N1, push 0x55.
  - `uart_tx` reads 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - Start bit at N+2, frame lasts 40 cycles, then `busy=0`.
- **Parity modes:** `cfg_div=1`, 8 data bits, push 0x07.
  - Even parity gives a parity bit of 1; odd parity gives 0.
  - Frame lasts 22 cycles.
- **Short frame, two stop bits:** `cfg_bits=2` (7 bits), `cfg_stop2=1`, `cfg_div=0`, push 0xFF.
  - Line reads 0, then seven 1s, then two stop 1s.
  - Bit 7 is never sent; frame lasts 10 cycles.
- **Full FIFO and back-to-back:** `FIFO_DEPTH=4`, `cfg_div=15`, hold `tx_valid` with 0x01..0x06.
  - Exactly 5 bytes are accepted (one already in the shifter) before `tx_ready=0`.
  - All 5 go out back-to-back with no idle cycles, in push order.
- **Config change mid-frame:** change `cfg_div` from 3 to 7 during the DATA state.
  - The current frame keeps 4-cycle bits.
  - The next frame uses 8-cycle bits.
- **Reset mid-frame:** assert `reset` during DATA with 3 bytes queued.
  - `uart_tx=1`, `busy=0` and `fifo_count=0` immediately, without waiting for a clock edge.
  - After release, nothing is transmitted until a new push.
